// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMulti  = 2'd1,
        StHalted = 2'd2
    } hz_state_e;

    localparam int unsigned DefaultMultiLat = 4;

    // Instruction word the pipe registers load when cleared.
    localparam logic [11:0] PipeNop = 12'hB11;

    typedef struct packed {
        logic pc_we;
        logic fd_we;
        logic fd_clr;
        logic de_we;
        logic de_clr;
        logic ec_we;
        logic ec_clr;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CtrlRun    = '{pc_we: 1'b1, fd_we: 1'b1, fd_clr: 1'b0, de_we: 1'b1,
                                          de_clr: 1'b0, ec_we: 1'b1, ec_clr: 1'b0};
    localparam pipe_ctrl_t CtrlFreeze = '{default: 1'b0};
    localparam pipe_ctrl_t CtrlMulti  = '{pc_we: 1'b0, fd_we: 1'b0, fd_clr: 1'b0, de_we: 1'b0,
                                          de_clr: 1'b0, ec_we: 1'b1, ec_clr: 1'b1};
    localparam pipe_ctrl_t CtrlFlush  = '{pc_we: 1'b1, fd_we: 1'b1, fd_clr: 1'b1, de_we: 1'b1,
                                          de_clr: 1'b1, ec_we: 1'b1, ec_clr: 1'b0};
    localparam pipe_ctrl_t CtrlBubble = '{pc_we: 1'b0, fd_we: 1'b0, fd_clr: 1'b0, de_we: 1'b1,
                                          de_clr: 1'b1, ec_we: 1'b1, ec_clr: 1'b0};

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: decode reads a register an execute-stage load writes.
module pipe_hazard_detect (
    input  logic [3:0] src1_addr_i,
    input  logic [3:0] src2_addr_i,
    input  logic [1:0] src_used_i,
    input  logic       mem_load_i,
    input  logic       reg_write_en_i,
    input  logic [3:0] reg_write_addr_i,
    output logic       load_use_o
);

    logic src1_hit, src2_hit;

    assign src1_hit   = src_used_i[0] && (src1_addr_i == reg_write_addr_i);
    assign src2_hit   = src_used_i[1] && (src2_addr_i == reg_write_addr_i);
    assign load_use_o = mem_load_i && reg_write_en_i && (src1_hit || src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the fetch/decode/execute/commit pipe.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULTI_LAT = DefaultMultiLat,
    parameter int unsigned CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] src1_addr_D,
    input  logic [3:0] src2_addr_D,
    input  logic [1:0] src_used_D,
    input  logic       mem_load_E,
    input  logic       reg_write_en_E,
    input  logic [3:0] reg_write_addr_E,
    input  logic       multi_start_E,
    input  logic       branch_taken_E,
    input  logic       mem_busy,
    input  logic       halt_C,
    input  logic       resume,
    output logic       pc_write_en,
    output logic       write_enable_FD,
    output logic       clear_FD,
    output logic       write_enable_DE,
    output logic       clear_DE,
    output logic       write_enable_EC,
    output logic       clear_EC,
    output logic       halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] CntLoad = (MULTI_LAT > 1) ? CNT_W'(MULTI_LAT - 2) : '0;

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pipe_ctrl_t       ctrl;
    logic             load_use;
    logic             branch_flush;

    pipe_hazard_detect u_detect (
        .src1_addr_i      (src1_addr_D),
        .src2_addr_i      (src2_addr_D),
        .src_used_i       (src_used_D),
        .mem_load_i       (mem_load_E),
        .reg_write_en_i   (reg_write_en_E),
        .reg_write_addr_i (reg_write_addr_E),
        .load_use_o       (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl         = CtrlRun;
        halted       = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            ctrl = CtrlFreeze;
        end else if (state_q == StHalted) begin
            ctrl   = CtrlFreeze;
            halted = 1'b1;
            if (resume) state_d = StRun;
        end else if (mem_busy) begin
            ctrl = CtrlFreeze;
        end else if (state_q == StRun && halt_C) begin
            ctrl    = CtrlFreeze;
            state_d = StHalted;
        end else if (state_q == StMulti) begin
            // Counter at zero is the release cycle; hazards are not looked at here.
            if (cnt_q != '0) begin
                ctrl  = CtrlMulti;
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                state_d = StRun;
            end
        end else if (multi_start_E && (MULTI_LAT > 1)) begin
            ctrl    = CtrlMulti;
            cnt_d   = CntLoad;
            state_d = StMulti;
        end else if (branch_taken_E) begin
            ctrl         = CtrlFlush;
            branch_flush = 1'b1;
        end else if (load_use) begin
            ctrl = CtrlBubble;
        end
    end

    assign pc_write_en     = ctrl.pc_we;
    assign write_enable_FD = ctrl.fd_we;
    assign clear_FD        = ctrl.fd_clr;
    assign write_enable_DE = ctrl.de_we;
    assign clear_DE        = ctrl.de_clr;
    assign write_enable_EC = ctrl.ec_we;
    assign clear_EC        = ctrl.ec_clr;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write_en && state_q != StHalted && stall_cycles_q != 16'hFFFF) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (branch_flush && flush_count_q != 16'hFFFF) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-by-cycle behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned Lat = 4;

    // {pc, we_FD, clr_FD, we_DE, clr_DE, we_EC, clr_EC, halted}
    localparam logic [7:0] RunV    = 8'b1101_0100;
    localparam logic [7:0] StallV  = 8'b0000_0110;
    localparam logic [7:0] FlushV  = 8'b1111_1100;
    localparam logic [7:0] BubbleV = 8'b0001_1100;
    localparam logic [7:0] HaltV   = 8'b0000_0001;
    localparam logic [7:0] ZeroV   = 8'b0000_0000;

    logic       clk, rst;
    logic [3:0] src1_addr_D, src2_addr_D, reg_write_addr_E;
    logic [1:0] src_used_D;
    logic       mem_load_E, reg_write_en_E, multi_start_E, branch_taken_E;
    logic       mem_busy, halt_C, resume;
    logic       pc_write_en, write_enable_FD, clear_FD, write_enable_DE, clear_DE;
    logic       write_enable_EC, clear_EC, halted;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(
        .MULTI_LAT (Lat),
        .CNT_W     (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .src1_addr_D      (src1_addr_D),
        .src2_addr_D      (src2_addr_D),
        .src_used_D       (src_used_D),
        .mem_load_E       (mem_load_E),
        .reg_write_en_E   (reg_write_en_E),
        .reg_write_addr_E (reg_write_addr_E),
        .multi_start_E    (multi_start_E),
        .branch_taken_E   (branch_taken_E),
        .mem_busy         (mem_busy),
        .halt_C           (halt_C),
        .resume           (resume),
        .pc_write_en      (pc_write_en),
        .write_enable_FD  (write_enable_FD),
        .clear_FD         (clear_FD),
        .write_enable_DE  (write_enable_DE),
        .clear_DE         (clear_DE),
        .write_enable_EC  (write_enable_EC),
        .clear_EC         (clear_EC),
        .halted           (halted)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] act_v;
    assign act_v = {pc_write_en, write_enable_FD, clear_FD, write_enable_DE, clear_DE,
                    write_enable_EC, clear_EC, halted};

    // Model: a halted flag plus a queue of scheduled multi-cycle actions (1 = stall, 0 = release).
    logic       m_halted = 1'b0;
    int         plan[$];
    logic [7:0] exp_v;
    logic       m_lu;
    int         item;

    always @(negedge clk) begin
        m_lu = mem_load_E && reg_write_en_E &&
               ((src_used_D[0] && src1_addr_D == reg_write_addr_E) ||
                (src_used_D[1] && src2_addr_D == reg_write_addr_E));
        if (rst) begin
            exp_v    = ZeroV;
            m_halted = 1'b0;
            plan.delete();
        end else if (m_halted) begin
            exp_v = HaltV;
            if (resume) m_halted = 1'b0;
        end else if (mem_busy) begin
            exp_v = ZeroV;
        end else if (plan.size() == 0 && halt_C) begin
            exp_v    = ZeroV;
            m_halted = 1'b1;
        end else if (plan.size() != 0) begin
            item  = plan.pop_front();
            exp_v = (item == 1) ? StallV : RunV;
        end else if (multi_start_E && Lat > 1) begin
            exp_v = StallV;
            for (int i = 0; i < int'(Lat) - 2; i++) plan.push_back(1);
            plan.push_back(0);
        end else if (branch_taken_E) begin
            exp_v = FlushV;
        end else if (m_lu) begin
            exp_v = BubbleV;
        end else begin
            exp_v = RunV;
        end
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got %b expected %b", $time, act_v, exp_v);
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src1_addr_D      = 4'd0;
        src2_addr_D      = 4'd0;
        src_used_D       = 2'b00;
        mem_load_E       = 1'b0;
        reg_write_en_E   = 1'b0;
        reg_write_addr_E = 4'd0;
        multi_start_E    = 1'b0;
        branch_taken_E   = 1'b0;
        mem_busy         = 1'b0;
        halt_C           = 1'b0;
        resume           = 1'b0;
    endtask

    // Load into r3 in execute; decode reads r3 through the selected source port(s).
    task automatic set_load_use(input logic [1:0] used);
        mem_load_E       = 1'b1;
        reg_write_en_E   = 1'b1;
        reg_write_addr_E = 4'd3;
        src1_addr_D      = 4'd3;
        src2_addr_D      = 4'd3;
        src_used_D       = used;
    endtask

    // {busy, halt, multi, branch, load_use}
    logic [4:0] combos[7] = '{5'b10010, 5'b00110, 5'b01100, 5'b11000,
                              5'b00001, 5'b00101, 5'b01010};

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", act_v, ZeroV);
        rst = 1'b0;
        #1;
        check("run_defaults_after_reset", act_v, RunV);
        tick();

        // Load-use on src2.
        set_load_use(2'b10);
        src1_addr_D = 4'd5;
        #1;
        check("load_use_bubble", act_v, BubbleV);
        tick();
        idle();
        #1;
        check("load_use_one_bubble_only", act_v, RunV);
        tick();

        // Address match on src2 but src2 unused: no hazard.
        set_load_use(2'b01);
        src1_addr_D = 4'd7;
        #1;
        check("unused_src_no_hazard", act_v, RunV);
        tick();
        idle();

        // Multi-cycle op: three stall cycles then release.
        multi_start_E = 1'b1;
        #1;
        check("multi_start_stall", act_v, StallV);
        tick();
        multi_start_E = 1'b0;
        check("multi_stall_2", act_v, StallV);
        tick();
        check("multi_stall_3", act_v, StallV);
        tick();
        check("multi_release", act_v, RunV);
        tick();
        check("multi_back_in_run", act_v, RunV);

        // Branch wins over a simultaneous load-use.
        set_load_use(2'b11);
        branch_taken_E = 1'b1;
        #1;
        check("branch_over_load_use", act_v, FlushV);
        tick();
        idle();

        // mem_busy for 5 cycles while the counter sits at 1.
        multi_start_E = 1'b1;
        tick();
        multi_start_E = 1'b0;
        tick();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("busy_freeze", act_v, ZeroV);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check("busy_last_stall", act_v, StallV);
        tick();
        check("busy_release", act_v, RunV);
        tick();

        // HALT and resume; other inputs ignored while halted.
        halt_C = 1'b1;
        #1;
        check("halt_c_freeze", act_v, ZeroV);
        tick();
        halt_C         = 1'b0;
        branch_taken_E = 1'b1;
        mem_busy       = 1'b1;
        #1;
        check("halted_ignores_inputs", act_v, HaltV);
        tick();
        idle();
        tick();
        resume = 1'b1;
        #1;
        check("halted_during_resume", act_v, HaltV);
        tick();
        resume = 1'b0;
        check("resume_run_defaults", act_v, RunV);
        tick();

        // Reset in MULTI, then a full multi op to show the counter restarted.
        multi_start_E = 1'b1;
        tick();
        multi_start_E = 1'b0;
        rst = 1'b1;
        #1;
        check("reset_mid_multi", act_v, ZeroV);
        tick();
        rst = 1'b0;
        #1;
        check("after_reset_run", act_v, RunV);
        tick();
        multi_start_E = 1'b1;
        tick();
        multi_start_E = 1'b0;
        repeat (4) tick();

        // Priority combinations, each followed by recovery cycles.
        foreach (combos[k]) begin
            idle();
            mem_busy       = combos[k][4];
            halt_C         = combos[k][3];
            multi_start_E  = combos[k][2];
            branch_taken_E = combos[k][1];
            if (combos[k][0]) set_load_use(2'b01);
            tick();
            idle();
            resume = 1'b1;
            tick();
            resume = 1'b0;
            repeat (4) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 4-stage core (fetch, decode, execute, commit).
- Drives write_enable_*/clear_* of the FD, DE and EC pipeline registers, plus the PC write enable.
- Resolves load-use interlocks, taken-branch flushes, multi-cycle execute ops, memory wait and HALT.
- Pipeline-register controls are combinational from the registered FSM state plus same-cycle stage inputs. Only the FSM and counters are sequential.

Parameters:
MULTI_LAT, 4, total execute cycles of a multi-cycle op (>=1); the block inserts MULTI_LAT-1 stall cycles.
CNT_W, 3, width of the multi-cycle down-counter; must satisfy 2^CNT_W >= MULTI_LAT.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
src1_addr_D  in  4  decode-stage source 1 register
src2_addr_D  in  4  decode-stage source 2 register
src_used_D  in  2  bit0/bit1: src1/src2 actually read
mem_load_E  in  1  execute-stage instruction is a load
reg_write_en_E  in  1  execute-stage instruction writes a register
reg_write_addr_E  in  4  execute-stage destination
multi_start_E  in  1  execute-stage instruction is multi-cycle
branch_taken_E  in  1  execute-stage branch resolved taken
mem_busy  in  1  data memory not ready; freeze whole pipe
halt_C  in  1  commit-stage instruction is HALT
resume  in  1  single-cycle pulse leaving HALTED
pc_write_en  out  1  PC update enable
write_enable_FD, clear_FD  out  1,1  FD register controls
write_enable_DE, clear_DE  out  1,1  DE register controls
write_enable_EC, clear_EC  out  1,1  EC register controls
halted  out  1  core halted

Behaviour:
- States: RUN, MULTI, HALTED. Reset puts the FSM in RUN and the counter at 0.
- While rst is high, all outputs are 0. From the first cycle after reset, RUN defaults apply.
- RUN default: all write enables = 1, all clears = 0.
- Evaluation priority per cycle: HALTED > mem_busy > halt_C > MULTI/multi_start_E > branch_taken_E > load-use.
- HALTED:
  - All enables = 0, clears = 0, halted = 1.
  - resume moves the FSM to RUN next cycle. All other inputs are ignored.
- mem_busy (any non-HALTED state): all enables = 0, clears = 0.
  - State and counter hold.
  - A pending branch or hazard is re-evaluated after busy drops, because stage inputs are frozen.
- halt_C in RUN: all enables = 0 that cycle; the FSM enters HALTED next cycle.
- multi_start_E in RUN with MULTI_LAT > 1:
  - pc_write_en = write_enable_FD = write_enable_DE = 0.
  - write_enable_EC = 1 with clear_EC = 1 (bubble into commit).
  - cnt <= MULTI_LAT-2; the FSM enters MULTI.
  - With MULTI_LAT = 1 the input is ignored.
- MULTI:
  - cnt != 0: same stall pattern as above, cnt decrements.
  - cnt == 0: RUN defaults (release); the FSM returns to RUN.
  - Total stall = MULTI_LAT-1 cycles. branch_taken_E and load-use are not evaluated in MULTI.
- branch_taken_E (RUN): pc_write_en = 1, clear_FD = 1, clear_DE = 1, write_enable_EC = 1. No state change.
- Load-use: mem_load_E && reg_write_en_E && (src_used_D[0] && src1_addr_D == reg_write_addr_E, or src_used_D[1] && src2_addr_D == reg_write_addr_E).
  - Response: pc_write_en = 0, write_enable_FD = 0, clear_DE = 1, write_enable_EC = 1. Exactly one bubble.
- Simultaneous branch + load-use: branch wins, because the decode instruction is squashed.
- Asynchronous reset mid-MULTI or in HALTED: the FSM returns to RUN and the counter to 0 immediately.

Optional Feature:
PIPE_PERF_CNT_EN
- With it: outputs stall_cycles (16 bits) and flush_count (16 bits), both saturating at 0xFFFF and reset to 0.
  - stall_cycles increments on any cycle with pc_write_en = 0 outside HALTED.
  - flush_count increments per branch flush.
- Without it: the ports and counters are absent.

Decomposition:
- Shared package holds: the state enum (RUN=2'd0, MULTI=2'd1, HALTED=2'd2), default MULTI_LAT, and the NOP encoding 12'hB11 used by the pipe registers on clear.
- Inline localparams serve as fallback where Yosys lacks package support.
- One natural sub-module: pipe_hazard_detect, a combinational load-use comparator.

Test Plan:
- Load r3 in E, decode reads r3 as src2 -> one cycle of pc_write_en = 0, write_enable_FD = 0, clear_DE = 1; then RUN defaults.
- MULTI_LAT=4, multi_start_E pulse -> 3 stall cycles with clear_EC = 1, then release; FSM back in RUN.
- branch_taken_E plus a simultaneous load-use hazard -> clear_FD = clear_DE = 1, pc_write_en = 1, no stall.
- mem_busy for 5 cycles mid-MULTI (cnt=1) -> all enables 0 for 5 cycles, cnt holds at 1, then 1 more stall and release.
- halt_C -> halted = 1 from the next cycle, all enables 0; resume pulse -> RUN defaults the next cycle.
- rst asserted in MULTI -> all outputs 0 immediately; after deassert, RUN defaults with cnt = 0.
